// File: rtl/delta_scheduler.sv
// delta_scheduler: round-robin arbiter sharing one XOR delta engine
// between NUM_CH requesters, with result buffer, watchdog and counter.
module delta_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [NUM_CH-1:0]    req_valid,
  output logic [NUM_CH-1:0]    req_ready,
  input  logic [NUM_CH*64-1:0] req_prev,
  input  logic [NUM_CH*64-1:0] req_curr,
  output logic                 eng_enable,
  output logic                 eng_words_valid,
  output logic [63:0]          eng_prev_word,
  output logic [63:0]          eng_curr_word,
  input  logic [63:0]          eng_delta_word,
  input  logic                 eng_event_valid,
  input  logic                 eng_output_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [63:0]          res_delta,
  output logic                 res_event,
  output logic [CH_W-1:0]      res_ch,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          event_count,
  input  logic                 cnt_clr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q;
  logic [CH_W-1:0]   last_q;
  logic [CH_W-1:0]   cur_ch_q;
  logic [7:0]        wd_q;
  logic [NUM_CH-1:0] elig;
  logic [CH_W-1:0]   grant_id;
  logic              grant_found;
  logic              can_accept;
  logic              accept;
  logic              cap;
  logic              wd_fire;

  assign elig       = req_valid & ch_mask;
  assign can_accept = !res_valid || res_ready;
  assign accept     = rst_n && (state_q == S_IDLE)
                      && can_accept && grant_found;
  assign cap        = (state_q == S_WAIT) && eng_output_ready;
  assign wd_fire    = (state_q == S_WAIT) && !eng_output_ready
                      && (wd_q == 8'(TIMEOUT - 1));

  assign eng_enable      = (state_q == S_ISSUE);
  assign eng_words_valid = (state_q == S_ISSUE);
  assign busy            = (state_q != S_IDLE);

  // Round-robin search upward from the channel after the last grant
  always_comb begin
    int idx;
    idx         = 0;
    grant_id    = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_q) + k) % NUM_CH;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_id    = CH_W'(idx);
      end
    end
  end

  // One-hot accept strobe for the granted channel only
  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready = NUM_CH'(1) << grant_id;
  end

  // Control FSM, engine word latch and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      last_q        <= CH_W'(NUM_CH - 1);
      cur_ch_q      <= '0;
      wd_q          <= '0;
      eng_prev_word <= '0;
      eng_curr_word <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            eng_prev_word <= req_prev[64*int'(grant_id) +: 64];
            eng_curr_word <= req_curr[64*int'(grant_id) +: 64];
            cur_ch_q      <= grant_id;
            last_q        <= grant_id;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wd_q <= wd_q + 8'd1;
          if (cap || wd_fire)
            state_q <= S_DRAIN;
        end
        S_DRAIN: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result buffer: a new capture wins over a same-cycle drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_delta <= '0;
      res_event <= 1'b0;
      res_ch    <= '0;
    end else if (cap) begin
      res_valid <= 1'b1;
      res_delta <= eng_delta_word;
      res_event <= eng_event_valid;
      res_ch    <= cur_ch_q;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Status: saturating event counter and sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count <= '0;
      timeout_err <= 1'b0;
    end else if (cnt_clr) begin
      event_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (cap && eng_event_valid && event_count != 16'hFFFF)
        event_count <= event_count + 16'd1;
      if (wd_fire)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_delta_scheduler.sv
// tb_delta_scheduler: directed checks of arbitration, result port,
// backpressure, watchdog, counter saturation and reset.
module tb_delta_scheduler;

  logic         clk;
  logic         rst_n;
  logic [3:0]   ch_mask;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_prev;
  logic [255:0] req_curr;
  logic         eng_enable;
  logic         eng_words_valid;
  logic [63:0]  eng_prev_word;
  logic [63:0]  eng_curr_word;
  logic [63:0]  eng_delta_word;
  logic         eng_event_valid;
  logic         eng_output_ready;
  logic         res_valid;
  logic         res_ready;
  logic [63:0]  res_delta;
  logic         res_event;
  logic [1:0]   res_ch;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  event_count;
  logic         cnt_clr;

  int n_chk;
  int n_err;
  int gq[$];
  int rq_ch[$];
  int rq_ev[$];
  logic [63:0] rq_d[$];
  int pulses;

  logic        eng_dead;
  logic        p1;
  logic        p2;
  logic [63:0] m_d;

  delta_scheduler dut (
    .clk(clk), .rst_n(rst_n), .ch_mask(ch_mask),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_prev(req_prev), .req_curr(req_curr),
    .eng_enable(eng_enable), .eng_words_valid(eng_words_valid),
    .eng_prev_word(eng_prev_word), .eng_curr_word(eng_curr_word),
    .eng_delta_word(eng_delta_word), .eng_event_valid(eng_event_valid),
    .eng_output_ready(eng_output_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_delta(res_delta), .res_event(res_event), .res_ch(res_ch),
    .busy(busy), .timeout_err(timeout_err),
    .event_count(event_count), .cnt_clr(cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: result strobe two cycles after the input pulse,
  // event when more than one bit changed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1  <= 1'b0;
      p2  <= 1'b0;
      m_d <= '0;
    end else begin
      p1 <= eng_words_valid;
      p2 <= p1;
      if (eng_words_valid)
        m_d <= eng_prev_word ^ eng_curr_word;
    end
  end
  assign eng_output_ready = p2 && !eng_dead;
  assign eng_delta_word   = m_d;
  assign eng_event_valid  = ($countones(m_d) > 1);

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    ch_mask   = 4'hF;
    res_ready = 1'b1;
    cnt_clr   = 1'b0;
    eng_dead  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_words(int ch, logic [63:0] p, logic [63:0] c);
    req_prev[64*ch +: 64] = p;
    req_curr[64*ch +: 64] = c;
  endtask

  // Sample each cycle: grants, engine pulses, handshaked results
  task automatic run(int ncyc);
    gq.delete();
    rq_ch.delete();
    rq_ev.delete();
    rq_d.delete();
    pulses = 0;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      for (int i = 0; i < 4; i++)
        if (req_ready[i]) gq.push_back(i);
      if (eng_words_valid) pulses++;
      if (res_valid && res_ready) begin
        rq_ch.push_back(int'(res_ch));
        rq_ev.push_back(int'(res_event));
        rq_d.push_back(res_delta);
      end
      @(negedge clk);
    end
  endtask

  task automatic fill_rr();
    for (int i = 0; i < 4; i++)
      set_words(i, {16'(i + 5), 48'h0},
                {16'(i + 5), 48'h0} ^ (64'd1 << i));
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    req_prev = '0;
    req_curr = '0;
    rst_n    = 1'b0;
    ch_mask  = 4'hF;
    req_valid = 4'hF;
    res_ready = 1'b1;
    cnt_clr   = 1'b0;
    eng_dead  = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_evcnt", 64'(event_count), 64'h0);
    chk("rst_tmo", 64'(timeout_err), 64'h0);
    chk("rst_prev", eng_prev_word, 64'h0);
    chk("rst_ev", 64'(eng_words_valid), 64'h0);

    // Single request from ch2
    do_reset();
    set_words(2, 64'h0, 64'hFF);
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(req_ready), 64'h4);
    @(negedge clk);
    chk("single_ready_off", 64'(req_ready), 64'h0);
    chk("single_pulse", 64'(eng_words_valid), 64'h1);
    chk("single_en", 64'(eng_enable), 64'h1);
    chk("single_curr", eng_curr_word, 64'hFF);
    req_valid = '0;
    @(negedge clk);
    chk("single_pulse_off", 64'(eng_words_valid), 64'h0);
    @(negedge clk);
    chk("single_not_yet", 64'(res_valid), 64'h0);
    @(negedge clk);
    chk("single_res_valid", 64'(res_valid), 64'h1);
    chk("single_delta", res_delta, 64'hFF);
    chk("single_event", 64'(res_event), 64'h1);
    chk("single_ch", 64'(res_ch), 64'h2);
    chk("single_evcnt", 64'(event_count), 64'h1);
    @(negedge clk);
    chk("single_drained", 64'(res_valid), 64'h0);

    // Round robin with every channel valid
    do_reset();
    fill_rr();
    req_valid = 4'hF;
    run(25);
    req_valid = '0;
    chk("rr_ngrant", 64'(gq.size()), 64'd5);
    chk("rr_nres", 64'(rq_ch.size()), 64'd5);
    if (gq.size() == 5 && rq_ch.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_grant", 64'(gq[k]), 64'(k % 4));
        chk("rr_res_ch", 64'(rq_ch[k]), 64'(k % 4));
        chk("rr_res_ev", 64'(rq_ev[k]), 64'h0);
        chk("rr_delta", rq_d[k], 64'd1 << (k % 4));
      end
    end
    chk("rr_evcnt", 64'(event_count), 64'h0);

    // Mask: only ch1 and ch3
    do_reset();
    fill_rr();
    ch_mask   = 4'b1010;
    req_valid = 4'hF;
    run(20);
    req_valid = '0;
    chk("mask_ngrant", 64'(gq.size()), 64'd4);
    if (gq.size() == 4)
      for (int k = 0; k < 4; k++)
        chk("mask_grant", 64'(gq[k]), (k % 2 == 0) ? 64'd1 : 64'd3);

    // Backpressure holds the first result and blocks new grants
    do_reset();
    fill_rr();
    res_ready = 1'b0;
    req_valid = 4'hF;
    run(20);
    chk("bp_ngrant", 64'(gq.size()), 64'd1);
    chk("bp_pulses", 64'(pulses), 64'd1);
    chk("bp_res_valid", 64'(res_valid), 64'h1);
    chk("bp_res_ch", 64'(res_ch), 64'h0);
    chk("bp_delta", res_delta, 64'h1);
    res_ready = 1'b1;
    run(10);
    req_valid = '0;
    chk("bp_resume_n", 64'(gq.size()), 64'd2);
    if (gq.size() > 0)
      chk("bp_resume_grant", 64'(gq[0]), 64'd1);
    if (rq_ch.size() > 0)
      chk("bp_first_res", 64'(rq_ch[0]), 64'd0);
    chk("bp_nres", 64'(rq_ch.size()), 64'd3);

    // Watchdog with a dead engine
    do_reset();
    @(negedge clk);
    eng_dead = 1'b1;
    set_words(0, 64'h0, 64'hF0);
    req_valid = 4'b0001;
    #1;
    chk("wd_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = '0;
    repeat (15) @(negedge clk);
    chk("wd_not_yet", 64'(timeout_err), 64'h0);
    chk("wd_busy", 64'(busy), 64'h1);
    @(negedge clk);
    chk("wd_fired", 64'(timeout_err), 64'h1);
    chk("wd_no_res", 64'(res_valid), 64'h0);
    @(negedge clk);
    chk("wd_idle", 64'(busy), 64'h0);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("wd_clr", 64'(timeout_err), 64'h0);

    // Saturation from a preloaded count
    do_reset();
    @(negedge clk);
    force dut.event_count = 16'hFFFE;
    #1;
    release dut.event_count;
    set_words(0, 64'h0, 64'h3);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("sat_reach", 64'(event_count), 64'hFFFF);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("sat_hold", 64'(event_count), 64'hFFFF);
    chk("sat_res_ev", 64'(res_event), 64'h1);

    // Reset during WAIT clears everything at once
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("mid_busy_pre", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'h0);
    chk("mid_prev", eng_curr_word, 64'h0);
    chk("mid_evcnt", 64'(event_count), 64'h0);
    chk("mid_res", 64'(res_valid), 64'h0);
    chk("mid_ready", 64'(req_ready), 64'h0);
    chk("mid_tmo", 64'(timeout_err), 64'h0);

    // cnt_clr beats a same-cycle increment
    do_reset();
    set_words(1, 64'h0, 64'h7);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_res", 64'(res_valid), 64'h1);
    chk("clr_prio", 64'(event_count), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/delta_scheduler.md
# delta_scheduler

Round-robin scheduler that shares one 64-bit XOR delta engine (`delta_core`) between `NUM_CH` voxel-stream requesters. It accepts a previous/current word pair from one channel at a time and issues it to the engine as a one-cycle pulse. It then waits for the engine's result and returns the delta, the event flag and the channel ID through a valid/ready result port. A watchdog and a saturating event counter provide status for the host interface.

## Interface
- `NUM_CH`, 4: number of requester channels (2..8).
- `CH_W`, 2: channel ID width, equal to clog2(`NUM_CH`).
- `TIMEOUT`, 15: maximum number of WAIT cycles before the watchdog fires (1..255).

Clock and reset: clk, asynchronous active-low rst_n.
- `clk`  in  1  system clock (27 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `ch_mask`  in  NUM_CH  1 means the channel is eligible for grant.
- `req_valid`  in  NUM_CH  per-channel request valid.
- `req_ready`  out  NUM_CH  one-hot grant/accept, combinational.
- `req_prev`  in  NUM_CH*64  previous words; channel i uses bits [64i+63:64i].
- `req_curr`  in  NUM_CH*64  current words; same packing as `req_prev`.
- `eng_enable`  out  1  engine enable.
- `eng_words_valid`  out  1  engine input valid.
- `eng_prev_word`  out  64  engine previous word.
- `eng_curr_word`  out  64  engine current word.
- `eng_delta_word`  in  64  engine delta output.
- `eng_event_valid`  in  1  engine event flag.
- `eng_output_ready`  in  1  engine result strobe.
- `res_valid`  out  1  result buffer holds a result.
- `res_ready`  in  1  consumer accepts the result.
- `res_delta`  out  64  captured delta.
- `res_event`  out  1  captured event flag.
- `res_ch`  out  CH_W  channel that produced the result.
- `busy`  out  1  state is not IDLE.
- `timeout_err`  out  1  sticky watchdog flag.
- `event_count`  out  16  saturating count of results with `res_event`=1.
- `cnt_clr`  in  1  synchronous clear of `event_count` and `timeout_err`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and DRAIN.
- **IDLE.** The scheduler may accept a request when `res_valid`=0, or when `res_valid`&`res_ready` (the buffer drains this same cycle).
  - Eligible channels are those with `req_valid`&`ch_mask`.
  - Grant goes to the first eligible channel searching upward (with wrap) from `last_grant`+1.
  - `req_ready` is asserted one-hot for the granted channel only, and is all-zero when nothing is eligible or acceptance is blocked.
  - On a grant, latch the channel's prev/curr words into `eng_prev_word`/`eng_curr_word`, record the channel ID, update `last_grant`, and go to ISSUE.
- **ISSUE.** Assert `eng_enable`=`eng_words_valid`=1 for exactly this cycle, clear the watchdog counter, and go to WAIT. Outside ISSUE both engine strobes are 0.
- **WAIT.** The watchdog counter increments each cycle.
  - On `eng_output_ready`=1: capture `eng_delta_word`, `eng_event_valid` and the channel ID into the result buffer, set `res_valid`, increment `event_count` if the event flag is set, and go to DRAIN.
  - If the counter reaches `TIMEOUT` with no `eng_output_ready`: set `timeout_err`, drop the request (no result is produced), and go to DRAIN.
- **DRAIN.** Hold for one cycle so the engine finishes its OUTPUT→IDLE step, then go to IDLE.
- **Result port.**
  - `res_*` are stable while `res_valid`=1 and `res_ready`=0.
  - `res_valid` clears on `res_valid`&`res_ready` unless a new capture occurs in the same cycle; in that case the new result loads and `res_valid` stays 1.
- **`event_count`.** Saturates at 16'hFFFF. `cnt_clr` takes priority over a same-cycle increment and over a same-cycle `timeout_err` set.
- **`ch_mask` changes** affect only future grants. An in-flight request always completes or times out.
- **`eng_output_ready` outside WAIT** is ignored.

## Timing
- **Reset values:**
  - state IDLE, `last_grant` = `NUM_CH`-1 (so ch0 has highest first priority).
  - All registered outputs are 0, including `eng_prev_word`/`eng_curr_word`, `res_*`, `timeout_err`, `event_count`.
  - `busy` is 0.
  - `req_ready` is 0 while `rst_n` is low.
- **Latency and throughput:**
  - Accept at the edge ending cycle a (IDLE). ISSUE occupies a+1.
  - With `delta_core`, `eng_output_ready` is high in a+3 and `res_valid` rises in a+4.
  - DRAIN occupies a+4, and the next accept is possible at the end of a+5.
  - Sustained throughput is one pair per 5 cycles when `res_ready`=1.
- **Backpressure:** if `res_ready`=0, no new acceptance occurs while `res_valid`=1, because the engine has no stall input.
- **Reset mid-operation:** all state is discarded immediately, with no result and no error.

## Test plan
- **Single request.** Reset, then ch2 requests with prev=0, curr=64'hFF. Required: `req_ready`=4'b0100 for one cycle; one `eng_words_valid` pulse; `res_valid` 4 cycles after accept with `res_delta`=64'hFF, `res_event`=1, `res_ch`=2; `event_count`=1.
- **Round-robin fairness.** All 4 channels hold valid continuously, with each channel's curr=prev^(1<<i) so every delta is 1 bit. Required: grants in order 0,1,2,3,0; `res_event`=0 on every result; `event_count` stays 0.
- **Mask.** `ch_mask`=4'b1010 with all channels valid. Required: only ch1 and ch3 are granted, alternating; ch0 and ch2 `req_ready` never assert.
- **Backpressure.** `res_ready`=0 after the first result. Required: `res_*` stay stable; no second grant; exactly one engine pulse. Releasing `res_ready` resumes grants.
- **Watchdog.** Replace the engine with a model that never asserts `eng_output_ready`. Required: `timeout_err`=1 after `TIMEOUT` WAIT cycles; no `res_valid`; the scheduler returns to IDLE; `cnt_clr` clears the flag.
- **Saturation and reset.** Preload 65535 events, then one more event. Required: `event_count` stays at 16'hFFFF. Asserting `rst_n`=0 during WAIT clears all outputs immediately.
